mux_scan_ctrl: RTL and testbench

- Upstream sequencer for the 4:1 behavioural mux in this design.
- Drives the mux select pair (b,a) through the enabled channels in ascending order.
- Waits a settle time on each channel, then captures the mux output bit.
- Presents the assembled 4-bit snapshot with a one-cycle valid pulse; supports single-shot and continuous scanning.

---
 rtl/mux_scan_ctrl_if.sv | 21 ++
 rtl/mux_scan_ctrl.sv | 91 +++++++++
 tb/tb_mux_scan_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if: control, mux select and snapshot signals between a scan requester and the scan controller.
interface mux_scan_ctrl_if;
    logic       start;
    logic       cont;
    logic       abort;
    logic [3:0] ch_mask;
    logic       mux_q;
    logic       sel_a;
    logic       sel_b;
    logic [3:0] sample;
    logic       valid;
    logic       busy;
    modport master (
        output start, cont, abort, ch_mask, mux_q,
        input  sel_a, sel_b, sample, valid, busy
    );
    modport slave (
        input  start, cont, abort, ch_mask, mux_q,
        output sel_a, sel_b, sample, valid, busy
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: walks a 4:1 mux through enabled channels in ascending order and captures a 4-bit snapshot.
module mux_scan_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input logic clk,
    input logic rst_n,
    mux_scan_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
    localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES);
    state_t state, state_n;
    logic [1:0] ch, ch_n, nxt_ch, first_ch;
    logic [3:0] cnt, cnt_n, mask, mask_n, shadow, shadow_n, sample, sample_n, merged;
    logic valid, valid_n, nxt_ok, go;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ch     <= '0;
            cnt    <= '0;
            mask   <= '0;
            shadow <= '0;
            sample <= '0;
            valid  <= 1'b0;
        end else begin
            state  <= state_n;
            ch     <= ch_n;
            cnt    <= cnt_n;
            mask   <= mask_n;
            shadow <= shadow_n;
            sample <= sample_n;
            valid  <= valid_n;
        end
    end
    always_comb begin
        state_n  = state;
        ch_n     = ch;
        cnt_n    = cnt;
        mask_n   = mask;
        shadow_n = shadow;
        sample_n = sample;
        valid_n  = 1'b0;
        go       = 1'b0;
        nxt_ok   = 1'b0;
        nxt_ch   = ch;
        first_ch = '0;
        // descending loops so the last hit is the lowest qualifying bit
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && i > int'(ch)) begin
                nxt_ok = 1'b1;
                nxt_ch = 2'(i);
            end
            if (bus.ch_mask[i]) first_ch = 2'(i);
        end
        merged     = shadow;
        merged[ch] = bus.mux_q;
        case (state)
            IDLE: go = bus.start && !bus.abort && |bus.ch_mask;
            SETTLE: begin
                if (bus.abort) state_n = IDLE;
                else if (cnt == 4'd1) begin
                    shadow_n = merged;
                    if (nxt_ok) begin
                        ch_n  = nxt_ch;
                        cnt_n = RELOAD;
                    end else begin
                        sample_n = merged;
                        valid_n  = 1'b1;
                        state_n  = DONE;
                    end
                end else cnt_n = cnt - 4'd1;
            end
            DONE: begin
                state_n = IDLE;
                go      = !bus.abort && bus.cont && |bus.ch_mask;
            end
            default: state_n = IDLE;
        endcase
        if (go) begin
            mask_n   = bus.ch_mask;
            shadow_n = '0;
            ch_n     = first_ch;
            cnt_n    = RELOAD;
            state_n  = SETTLE;
        end
    end
    assign bus.sel_a  = ch[0];
    assign bus.sel_b  = ch[1];
    assign bus.sample = sample;
    assign bus.valid  = valid;
    assign bus.busy   = state != IDLE;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: drives three controllers (settle 1, 2, 3) in lockstep, each closing the loop through its own 4:1 mux model.
module tb_mux_scan_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, cont = 1'b0, abort = 1'b0;
    logic [3:0] ch_mask = '0;
    logic [3:0] data = '0;
    logic [1:0] sel [3];
    logic [3:0] smp [3];
    logic vld [3], bsy [3];
    logic [3:0] exp_prev [3];
    int n_tests = 0, n_fail = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 3; g++) begin : gi
        mux_scan_ctrl_if bus();
        assign bus.start   = start;
        assign bus.cont    = cont;
        assign bus.abort   = abort;
        assign bus.ch_mask = ch_mask;
        assign bus.mux_q   = data[{bus.sel_b, bus.sel_a}];
        assign sel[g] = {bus.sel_b, bus.sel_a};
        assign smp[g] = bus.sample;
        assign vld[g] = bus.valid;
        assign bsy[g] = bus.busy;
        mux_scan_ctrl #(.SETTLE_CYCLES(g + 1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    end
    typedef struct {
        logic [3:0] mask;
        logic [3:0] dat;
        logic [3:0] exp_s;
    } vec_t;
    vec_t tbl [6];
    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[S=%0d] @%0t: got %0h expected %0h", nm, g + 1, $time, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk_idle(input string nm);
        for (int g = 0; g < 3; g++) begin
            chk({nm, "_busy"}, g, 32'(bsy[g]), 0);
            chk({nm, "_valid"}, g, 32'(vld[g]), 0);
            chk({nm, "_sample"}, g, 32'(smp[g]), 32'(exp_prev[g]));
        end
    endtask
    // Expected trace: edge k after start selects the (k/S)-th enabled channel; snapshot lands at edge N*S.
    task automatic run_scan(input logic [3:0] m, input logic [3:0] d, input logic [3:0] e, input bit stray);
        int n, s;
        int lst [4];
        n = 0;
        for (int i = 0; i < 4; i++) if (m[i]) begin lst[n] = i; n++; end
        ch_mask = m; data = d; start = 1'b1; cont = 1'b0; abort = 1'b0;
        for (int k = 0; k <= 3 * n + 2; k++) begin
            step();
            start = stray && k < n && $urandom_range(0, 1) == 1;
            if (stray) ch_mask = 4'($urandom);
            for (int g = 0; g < 3; g++) begin
                s = g + 1;
                chk("sel", g, 32'(sel[g]), 32'(lst[k < n * s ? k / s : n - 1]));
                chk("valid", g, 32'(vld[g]), 32'(k == n * s));
                chk("busy", g, 32'(bsy[g]), 32'(k <= n * s));
                chk("sample", g, 32'(smp[g]), 32'(k < n * s ? exp_prev[g] : e));
            end
        end
        start = 1'b0;
        for (int g = 0; g < 3; g++) exp_prev[g] = e;
    endtask
    initial begin
        logic a_prev, c_prev;
        int phase [3];
        bit act [3];
        logic [3:0] m, d;
        tbl[0] = '{4'b1111, 4'b1101, 4'b1101};
        tbl[1] = '{4'b1010, 4'b1111, 4'b1010};
        tbl[2] = '{4'b1000, 4'b1000, 4'b1000};
        tbl[3] = '{4'b0001, 4'b1110, 4'b0000};
        tbl[4] = '{4'b0110, 4'b0100, 4'b0100};
        tbl[5] = '{4'b1001, 4'b1001, 4'b1001};
        for (int g = 0; g < 3; g++) exp_prev[g] = '0;
        step();
        step();
        for (int g = 0; g < 3; g++) chk("reset_sel", g, 32'(sel[g]), 0);
        chk_idle("reset");
        rst_n = 1'b1;
        step();
        foreach (tbl[i]) run_scan(tbl[i].mask, tbl[i].dat, tbl[i].exp_s, 1'b0);
        // Empty mask: start is ignored
        ch_mask = 4'b0000; start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_idle("zero_mask");
        end
        start = 1'b0;
        // Abort in IDLE beats a simultaneous start
        ch_mask = 4'b1111; start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk_idle("abort_idle");
        step();
        chk_idle("abort_idle2");
        // Continuous mode on channel 0 with the A input toggling every cycle
        cont = 1'b1; ch_mask = 4'b0001; data = 4'b0000; start = 1'b1;
        step();
        start = 1'b0;
        for (int g = 0; g < 3; g++) begin phase[g] = 0; act[g] = 1'b1; end
        for (int k = 1; k <= 24; k++) begin
            a_prev = data[0];
            c_prev = cont;
            step();
            data[0] = ~data[0];
            cont = k < 12;
            for (int g = 0; g < 3; g++) begin
                if (act[g]) begin
                    phase[g]++;
                    if (phase[g] == g + 1) exp_prev[g] = {3'b000, a_prev};
                    else if (phase[g] == g + 2) begin
                        if (c_prev) phase[g] = 0;
                        else act[g] = 1'b0;
                    end
                end
                chk("cont_valid", g, 32'(vld[g]), 32'(act[g] && phase[g] == g + 1));
                chk("cont_busy", g, 32'(bsy[g]), 32'(act[g]));
                chk("cont_sample", g, 32'(smp[g]), 32'(exp_prev[g]));
                chk("cont_sel", g, 32'(sel[g]), 0);
            end
        end
        cont = 1'b0;
        // Abort mid-scan, including the S=1 completion edge
        run_scan(4'b0110, 4'b1111, 4'b0110, 1'b0);
        ch_mask = 4'b1111; data = 4'b1111; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_sel", 0, 32'(sel[0]), 3);
        chk("abort_sel", 1, 32'(sel[1]), 1);
        chk("abort_sel", 2, 32'(sel[2]), 1);
        chk_idle("abort");
        for (int k = 0; k < 3; k++) begin
            step();
            chk_idle("abort_after");
        end
        run_scan(4'b1111, 4'b1010, 4'b1010, 1'b0);
        // Abort while S=1 sits in DONE with cont set: no restart
        ch_mask = 4'b0001; data = 4'b1111; start = 1'b1; cont = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("done_valid", 0, 32'(vld[0]), 1);
        exp_prev[0] = 4'b0001;
        abort = 1'b1;
        step();
        abort = 1'b0; cont = 1'b0;
        chk_idle("abort_done");
        // Asynchronous reset in the middle of a scan
        ch_mask = 4'b1111; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        #3 rst_n = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            exp_prev[g] = '0;
            chk("async_rst_sel", g, 32'(sel[g]), 0);
        end
        chk_idle("async_rst");
        #2 rst_n = 1'b1;
        run_scan(4'b1111, 4'b0110, 4'b0110, 1'b0);
        for (int r = 0; r < 25; r++) begin
            m = 4'($urandom_range(1, 15));
            d = 4'($urandom);
            run_scan(m, d, m & d, 1'b1);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
